tlv8413_ramp_ctrl: RTL

- Slew-rate-limited setpoint scheduler placed in front of the dual-DAC8413 multiplexed interface.
- Holds a per-channel target for all 8 DAC channels, written through a simple write port.
- On every ramp tick, walks channels 0..7 one per clock and steps each current setpoint toward its target by at most STEP.
- Drives the 8 current setpoints to the interface block's channel inputs; that block emits a DA write whenever any value changes.

---
 rtl/tlv8413_pkg.sv | 20 ++
 rtl/tlv8413_ramp_step.sv | 35 +++
 rtl/tlv8413_ramp_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tlv8413_pkg.sv
// Shared definitions for the TLV8413 ramp controller slice.
//   NUM_CH    : number of DAC channels handled by the scheduler
//   DAC_DW    : DAC code width
//   state_t   : scan FSM encoding
//   ch_idx_t  : channel index type
//   code_t    : DAC code type
package tlv8413_pkg;

  localparam int NUM_CH = 8;
  localparam int DAC_DW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  typedef logic [2:0]        ch_idx_t;
  typedef logic [DAC_DW-1:0] code_t;

endpackage

// File: rtl/tlv8413_ramp_step.sv
// Combinational saturating stepper: moves cur toward tgt by at most STEP
// codes without ever passing the target.
//   cur  in  8  current setpoint
//   tgt  in  8  target code
//   nxt  out 8  next setpoint
module tlv8413_ramp_step
  import tlv8413_pkg::*;
#(
  parameter int STEP = 1
) (
  input  code_t cur,
  input  code_t tgt,
  output code_t nxt
);

  localparam logic [8:0] STEP_W = 9'(STEP);

  logic signed [8:0] diff;
  logic        [8:0] mag;
  logic        [8:0] amt;

  // 9-bit signed difference so the full 0..255 range never wraps
  assign diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});

  always_comb begin
    mag = diff[8] ? 9'(-diff) : 9'(diff);
    amt = (mag < STEP_W) ? mag : STEP_W;
    if (diff[8]) begin
      nxt = cur - amt[7:0];
    end else begin
      nxt = cur + amt[7:0];
    end
  end

endmodule

// File: rtl/tlv8413_ramp_ctrl.sv
// Slew-rate-limited setpoint scheduler in front of the dual-DAC8413
// multiplexed interface. Holds a target per channel; on every ramp tick
// walks channels 0..7, one per clock, stepping each setpoint toward its
// target by at most STEP codes.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   wr_en        in   single-cycle target write strobe
//   wr_ch        in   target channel index
//   wr_data      in   target code
//   wr_direct    in   (TLV8413_RAMP_DIRECT_WRITE_EN only) write cur as well
//   wr_ack       out  pulse the cycle after a write
//   halt         in   freeze the tick counter (level)
//   ch_busy      out  bit i = cur[i] != tgt[i], registered
//   all_settled  out  registered NOR of the per-channel busy terms
//   dac_db0..7   out  current setpoints
//
// Build option: define TLV8413_RAMP_DIRECT_WRITE_EN to add wr_direct, which
// loads cur and tgt together and bypasses the ramp.
//
// FSM states:
//   state   | meaning
//   ST_IDLE | waiting for a tick or a pending tick
//   ST_SCAN | stepping cur[idx], idx = 0..7, one channel per clock
module tlv8413_ramp_ctrl
  import tlv8413_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 22118400,
  parameter int TICK_US     = 1000,
  parameter int STEP        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_ch,
  input  logic [7:0] wr_data,
`ifdef TLV8413_RAMP_DIRECT_WRITE_EN
  input  logic       wr_direct,
`endif
  output logic       wr_ack,
  input  logic       halt,
  output logic [7:0] ch_busy,
  output logic       all_settled,
  output logic [7:0] dac_db0,
  output logic [7:0] dac_db1,
  output logic [7:0] dac_db2,
  output logic [7:0] dac_db3,
  output logic [7:0] dac_db4,
  output logic [7:0] dac_db5,
  output logic [7:0] dac_db6,
  output logic [7:0] dac_db7
);

  localparam int TICK_CNT = (CLK_FREQ_HZ / 1000000) * TICK_US;
  localparam int CNT_W    = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  state_t  state, state_nxt;
  ch_idx_t idx, idx_nxt;
  logic    pending, pending_nxt;
  logic    step_en;

  code_t tgt [NUM_CH];
  code_t cur [NUM_CH];
  code_t step_nxt;
  logic [NUM_CH-1:0] busy_c;

  // ---------------------------------------------------------------- tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!halt) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
    end
  end

  assign tick = !halt && (cnt == CNT_LAST);

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pending_nxt = pending;
    step_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick || pending) begin
          state_nxt   = ST_SCAN;
          idx_nxt     = '0;
          pending_nxt = 1'b0;
        end
      end
      ST_SCAN: begin
        step_en = 1'b1;
        idx_nxt = idx + 3'd1;
        if (idx == 3'd7) begin
          state_nxt = ST_IDLE;
        end
        // only one tick is remembered across a scan
        if (tick) begin
          pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------- channel state
  tlv8413_ramp_step #(
    .STEP (STEP)
  ) u_step (
    .cur (cur[idx]),
    .tgt (tgt[idx]),
    .nxt (step_nxt)
  );

  // The step reads tgt before this edge's write lands, so a colliding
  // write only takes effect on the following scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= '0;
        cur[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        tgt[wr_ch] <= wr_data;
      end
      if (step_en) begin
        cur[idx] <= step_nxt;
      end
`ifdef TLV8413_RAMP_DIRECT_WRITE_EN
      // later assignment wins over a same-channel scan step
      if (wr_en && wr_direct) begin
        cur[wr_ch] <= wr_data;
      end
`endif
    end
  end

  always_comb begin
    busy_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_c[i] = (cur[i] != tgt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack      <= 1'b0;
      ch_busy     <= '0;
      all_settled <= 1'b1;
    end else begin
      wr_ack      <= wr_en;
      ch_busy     <= busy_c;
      all_settled <= ~|busy_c;
    end
  end

  assign dac_db0 = cur[0];
  assign dac_db1 = cur[1];
  assign dac_db2 = cur[2];
  assign dac_db3 = cur[3];
  assign dac_db4 = cur[4];
  assign dac_db5 = cur[5];
  assign dac_db6 = cur[6];
  assign dac_db7 = cur[7];

endmodule
